// File: rtl/mprj_serial_loader.sv
// mprj_serial_loader
// Reads one configuration word per user IO pad and shifts the words, MSB
// first and highest pad first, into the pad configuration chain. It then
// pulses serial_load so the pads capture the new settings.
//   - Every output is a flop or a decode of the registered state.
//   - cfg_addr follows the pad index register, so it is valid in FETCH and
//     holds its value everywhere else.
//   - The shift register is empty once the last word has gone out, so
//     serial_data_out returns to 0 between transfers.
//   - CFG_BITS must be at least 2.

module mprj_serial_loader #(
  parameter int NUM_IO   = 38,
  parameter int CFG_BITS = 13,
  parameter int IDX_W    = 6
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                xfer_start,
  output logic [IDX_W-1:0]    cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                serial_clock,
  output logic                serial_data_out,
  output logic                serial_load,
  output logic                busy,
  output logic                xfer_done
);

  localparam int CNT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LOAD     = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [IDX_W-1:0]    idx_r;
  logic [CNT_W-1:0]    bit_cnt_r;
  logic [CFG_BITS-1:0] shreg_r;
  logic                done_r;
  logic                busy_s;
  logic                sclk_s;
  logic                load_s;

  // State register; reset aborts any transfer in progress.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode. A request is accepted only from IDLE, so requests made while busy are dropped.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (xfer_start) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH:    state_s = SHIFT_LO;
      SHIFT_LO: state_s = SHIFT_HI;
      SHIFT_HI: begin
        if (bit_cnt_r != {CNT_W{1'b0}}) begin
          state_s = SHIFT_LO;
        end else if (idx_r != {IDX_W{1'b0}}) begin
          state_s = FETCH;
        end else begin
          state_s = LOAD;
        end
      end
      LOAD:     state_s = IDLE;
      default:  state_s = IDLE;
    endcase
  end

  // Datapath: pad index, bit counter, shift register and the completion flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      idx_r     <= {IDX_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      shreg_r   <= {CFG_BITS{1'b0}};
      done_r    <= 1'b0;
    end else begin
      done_r <= (state_r == LOAD);
      case (state_r)
        IDLE: begin
          if (xfer_start) begin
            idx_r <= IDX_W'(NUM_IO - 1);
          end else begin
            idx_r <= idx_r;
          end
        end
        FETCH: begin
          shreg_r   <= cfg_data;
          bit_cnt_r <= CNT_W'(CFG_BITS - 1);
        end
        SHIFT_HI: begin
          // The shift happens on the edge after serial_clock rose, so the
          // data bit stays stable for the whole high phase.
          shreg_r <= shreg_r << 1;
          if (bit_cnt_r != {CNT_W{1'b0}}) begin
            bit_cnt_r <= bit_cnt_r - CNT_W'(1);
          end else if (idx_r != {IDX_W{1'b0}}) begin
            idx_r <= idx_r - IDX_W'(1);
          end else begin
            idx_r <= idx_r;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Output decode from the registered state.
  always_comb begin
    busy_s = 1'b0;
    sclk_s = 1'b0;
    load_s = 1'b0;
    case (state_r)
      IDLE:     busy_s = 1'b0;
      FETCH:    busy_s = 1'b1;
      SHIFT_LO: busy_s = 1'b1;
      SHIFT_HI: begin
        busy_s = 1'b1;
        sclk_s = 1'b1;
      end
      LOAD: begin
        busy_s = 1'b1;
        load_s = 1'b1;
      end
      default: busy_s = 1'b0;
    endcase
  end

  assign busy            = busy_s;
  assign serial_clock    = sclk_s;
  assign serial_load     = load_s;
  assign serial_data_out = shreg_r[CFG_BITS-1];
  assign cfg_addr        = idx_r;
  assign xfer_done       = done_r;

endmodule

// File: tb/tb_mprj_serial_loader.sv
// Directed bench for mprj_serial_loader: one instance at default sizes and
// one small instance (NUM_IO=2, CFG_BITS=3).

module tb_mprj_serial_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance
  logic        rst;
  logic        xfer_start;
  logic [5:0]  cfg_addr;
  logic [12:0] cfg_data;
  logic        sclk, sdo, sload, busy, done;

  assign cfg_data = {7'b0, cfg_addr};

  mprj_serial_loader dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .xfer_start      (xfer_start),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .serial_clock    (sclk),
    .serial_data_out (sdo),
    .serial_load     (sload),
    .busy            (busy),
    .xfer_done       (done)
  );

  // Small instance
  logic       s_rst;
  logic       s_start;
  logic [0:0] s_addr;
  logic [2:0] s_data;
  logic       s_sclk, s_sdo, s_load, s_busy, s_done;

  assign s_data = (s_addr == 1'b1) ? 3'b011 : 3'b101;

  mprj_serial_loader #(.NUM_IO(2), .CFG_BITS(3), .IDX_W(1)) dut_small (
    .wb_clk_i        (clk),
    .wb_rst_i        (s_rst),
    .xfer_start      (s_start),
    .cfg_addr        (s_addr),
    .cfg_data        (s_data),
    .serial_clock    (s_sclk),
    .serial_data_out (s_sdo),
    .serial_load     (s_load),
    .busy            (s_busy),
    .xfer_done       (s_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [493:0] chain;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Samples one cycle per falling edge. Cycle 0 is the first cycle after the start edge.
  task automatic observe(input int max_cyc, input int pa, input int pb, input int rst_at,
                         output int busy_cnt, output int load_cnt, output int rises,
                         output int load_cyc, output int done_cyc, output int overlap);
    logic prev;
    logic rst_pending;
    busy_cnt = 0; load_cnt = 0; rises = 0; load_cyc = -1; done_cyc = -1; overlap = 0;
    prev = 1'b0; rst_pending = 1'b0;
    chain = '0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (rst_pending) begin
        rst = 1'b0;
        rst_pending = 1'b0;
      end
      if (busy) busy_cnt++;
      if (sload) begin
        load_cnt++;
        load_cyc = c;
      end
      if (sload && sclk) overlap++;
      if (sclk && !prev) begin
        rises++;
        chain = {chain[492:0], sdo};
      end
      prev = sclk;
      xfer_start = (c == pa) || (c == pb);
      if (done) begin
        done_cyc = c;
        break;
      end
      if (c == rst_at) begin
        #2 rst = 1'b1;
        #1 check("async_rst_outputs", {21'd0, cfg_addr, busy, sclk, sdo, sload, done}, 32'd0);
        rst_pending = 1'b1;
      end
    end
  endtask

  task automatic check_chain(input string tag);
    for (int k = 0; k < 38; k++)
      check($sformatf("%s_seg%0d", tag, k), {19'd0, chain[13*k +: 13]}, k);
  endtask

  int bc, lc, rs, lcy, dcy, ov;

  initial begin
    rst = 1'b1; s_rst = 1'b1; xfer_start = 1'b0; s_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {21'd0, cfg_addr, busy, sclk, sdo, sload, done}, 32'd0);
    rst = 1'b0; s_rst = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Full transfer: timing and chain contents
    xfer_start = 1'b1;
    observe(2000, -1, -1, -1, bc, lc, rs, lcy, dcy, ov);
    check("a_busy_len", bc, 1027);
    check("a_load_cnt", lc, 1);
    check("a_load_cyc", lcy, 1026);
    check("a_done_cyc", dcy, 1027);
    check("a_rises", rs, 494);
    check("a_overlap", ov, 0);
    check_chain("a");

    // Starts while busy are ignored; a start in the xfer_done cycle begins a second transfer
    xfer_start = 1'b1;
    observe(2000, 5, 500, -1, bc, lc, rs, lcy, dcy, ov);
    check("b_busy_len", bc, 1027);
    check("b_load_cnt", lc, 1);
    check("b_done_cyc", dcy, 1027);
    xfer_start = 1'b1;
    observe(2000, -1, -1, -1, bc, lc, rs, lcy, dcy, ov);
    check("b2_busy_len", bc, 1027);
    check("b2_load_cyc", lcy, 1026);
    check("b2_done_cyc", dcy, 1027);

    // Reset partway through a transfer aborts it without a load pulse
    xfer_start = 1'b1;
    observe(1200, -1, -1, 300, bc, lc, rs, lcy, dcy, ov);
    check("c_load_cnt", lc, 0);
    check("c_done_cyc", dcy, -1);
    check("c_busy_after", {31'd0, busy}, 32'd0);
    xfer_start = 1'b1;
    observe(2000, -1, -1, -1, bc, lc, rs, lcy, dcy, ov);
    check("c2_busy_len", bc, 1027);
    check("c2_load_cnt", lc, 1);
    check("c2_rises", rs, 494);
    check_chain("c2");

    // Small instance: pad 1 = 011, then pad 0 = 101
    begin
      logic [5:0] stream;
      logic prev;
      int sb, sr, sl, sd;
      stream = '0; prev = 1'b0; sb = 0; sr = 0; sl = 0; sd = 0;
      s_start = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        s_start = 1'b0;
        if (s_busy) sb++;
        if (s_load) sl++;
        if (s_sclk && !prev) begin
          sr++;
          stream = {stream[4:0], s_sdo};
        end
        prev = s_sclk;
        if (s_done) begin
          sd = 1;
          break;
        end
      end
      check("s_stream", {26'd0, stream}, 32'b011101);
      check("s_busy_len", sb, 15);
      check("s_rises", sr, 6);
      check("s_load_cnt", sl, 1);
      check("s_done_seen", sd, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
